// File: rtl/phy_rx_ctrl_if.sv
// Receive sequencer bundle: decoder bit stream and control in, symbol stream out.
// master = phy_rx_ctrl side, slave = decoder/PHY side.
interface phy_rx_ctrl_if;
  logic       phy_rx_en;
  logic       dec_out;
  logic       dec_out_en;
  logic       phy_bmc_decoder_clr;
  logic       phy_bmc_decoder_dis;
  logic [4:0] rx_sym;
  logic       rx_sym_vld;
  logic       rx_sop;
  logic       rx_eop;
  logic       rx_err;
  logic       rx_busy;

  modport master (
    input  phy_rx_en,
    input  dec_out,
    input  dec_out_en,
    output phy_bmc_decoder_clr,
    output phy_bmc_decoder_dis,
    output rx_sym,
    output rx_sym_vld,
    output rx_sop,
    output rx_eop,
    output rx_err,
    output rx_busy
  );

  modport slave (
    output phy_rx_en,
    output dec_out,
    output dec_out_en,
    input  phy_bmc_decoder_clr,
    input  phy_bmc_decoder_dis,
    input  rx_sym,
    input  rx_sym_vld,
    input  rx_sop,
    input  rx_eop,
    input  rx_err,
    input  rx_busy
  );
endinterface

// File: rtl/phy_rx_ctrl.sv
// Receive-side sequencer for phy_bmc_decoder: preamble hunt, SOP alignment,
// 5-bit symbol packing, EOP / timeout / overflow detection and decoder re-arm.
// Optional feature: define PHY_RX_SOP_TOLERANT_EN to accept an SOP with one
// mismatching symbol among symbols 2..3.
module phy_rx_ctrl #(
  parameter int unsigned PREAMBLE_MIN = 16,
  parameter logic [9:0]  IDLE_TIMEOUT = 10'd64,
  parameter logic [9:0]  MAX_SYM      = 10'd600
) (
  input logic           clk,
  input logic           rst_n,
  phy_rx_ctrl_if.master bus
);

  localparam logic [4:0] Sync1 = 5'b11000;
  localparam logic [4:0] Sync2 = 5'b10001;
  localparam logic [4:0] Eop   = 5'b01101;

  localparam int unsigned AltW = $clog2(PREAMBLE_MIN + 1);
  localparam logic [AltW-1:0] AltMax = AltW'(PREAMBLE_MIN);

`ifdef PHY_RX_SOP_TOLERANT_EN
  localparam bit SopTolerant = 1'b1;
`else
  localparam bit SopTolerant = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StHunt, StSop, StData} state_e;

  state_e          state_q;
  logic            rx_en_q;
  logic [4:0]      sh_q;
  logic            prev_q;
  logic            prev_vld_q;
  logic [AltW-1:0] alt_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [1:0]      sym_idx_q;
  logic [9:0]      sym_cnt_q;
  logic [9:0]      idle_cnt_q;
  logic            mism_q;
  logic            clr_q;
  logic            dis_q;
  logic [4:0]      sym_q;
  logic            vld_q;
  logic            sop_q;
  logic            eop_q;
  logic            err_q;
  logic            busy_q;

  logic            bit_vld;
  logic [4:0]      sh_nxt;
  logic            sym_done;
  logic [9:0]      sym_cnt_inc;
  logic            idle_hit;
  logic [AltW-1:0] alt_nxt;
  logic [4:0]      exp_sym;
  logic            sym_ok;
  logic            sop_abort;
  logic            data_abort;
  logic            data_eop;

  // Per-bit decode: shifted value, alternation count and end-of-packet events.
  always_comb begin
    // A bit landing in the clear cycle belongs to the flushed decoder state.
    bit_vld     = bus.dec_out_en & ~clr_q;
    sh_nxt      = {bus.dec_out, sh_q[4:1]};
    sym_done    = bit_vld && (bit_cnt_q == 3'd4);
    sym_cnt_inc = sym_cnt_q + 10'd1;
    idle_hit    = !bit_vld && (idle_cnt_q == IDLE_TIMEOUT - 10'd1);

    // Once saturated the count holds, so the non-alternating Sync-1 bits
    // following the preamble do not disarm the hunt.
    if (!prev_vld_q) begin
      alt_nxt = AltW'(1);
    end else if (alt_cnt_q == AltMax) begin
      alt_nxt = AltMax;
    end else if (bus.dec_out != prev_q) begin
      alt_nxt = alt_cnt_q + AltW'(1);
    end else begin
      alt_nxt = '0;
    end

    exp_sym = (sym_idx_q == 2'd3) ? Sync2 : Sync1;
    sym_ok  = (sh_nxt == exp_sym) || (SopTolerant && (sym_idx_q >= 2'd2) && !mism_q);

    sop_abort  = (state_q == StSop) && ((sym_done && !sym_ok) || idle_hit);
    data_eop   = (state_q == StData) && sym_done && (sh_nxt == Eop);
    data_abort = (state_q == StData) &&
                 ((sym_done && (sh_nxt != Eop) && (sym_cnt_inc == MAX_SYM)) || idle_hit);
  end

  // Sequencer FSM with registered outputs; disable overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rx_en_q    <= 1'b0;
      sh_q       <= '0;
      prev_q     <= 1'b0;
      prev_vld_q <= 1'b0;
      alt_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sym_idx_q  <= '0;
      sym_cnt_q  <= '0;
      idle_cnt_q <= '0;
      mism_q     <= 1'b0;
      clr_q      <= 1'b0;
      dis_q      <= 1'b1;
      sym_q      <= '0;
      vld_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_en_q <= bus.phy_rx_en;
      clr_q   <= 1'b0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;

      if ((state_q != StIdle) && !bus.phy_rx_en) begin
        // busy stays up for the rx_err cycle and drops in IDLE
        state_q <= StIdle;
        dis_q   <= 1'b1;
        err_q   <= (state_q == StSop) || (state_q == StData);
      end else begin
        unique case (state_q)
          StIdle: begin
            dis_q      <= 1'b1;
            busy_q     <= 1'b0;
            sh_q       <= '0;
            prev_vld_q <= 1'b0;
            alt_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sym_idx_q  <= '0;
            sym_cnt_q  <= '0;
            idle_cnt_q <= '0;
            mism_q     <= 1'b0;
            if (bus.phy_rx_en && !rx_en_q) begin
              clr_q   <= 1'b1;
              dis_q   <= 1'b0;
              state_q <= StHunt;
            end
          end

          StHunt: begin
            dis_q      <= 1'b0;
            busy_q     <= 1'b0;
            idle_cnt_q <= bit_vld ? 10'd0 : idle_cnt_q + 10'd1;
            if (bit_vld) begin
              sh_q       <= sh_nxt;
              prev_q     <= bus.dec_out;
              prev_vld_q <= 1'b1;
              alt_cnt_q  <= alt_nxt;
              if ((alt_nxt == AltMax) && (sh_nxt == Sync1)) begin
                state_q   <= StSop;
                busy_q    <= 1'b1;
                bit_cnt_q <= '0;
                sym_idx_q <= 2'd1;
                mism_q    <= 1'b0;
              end
            end else if (idle_hit) begin
              alt_cnt_q  <= '0;
              clr_q      <= 1'b1;
              sh_q       <= '0;
              bit_cnt_q  <= '0;
              idle_cnt_q <= '0;
              prev_vld_q <= 1'b0;
            end
          end

          StSop: begin
            idle_cnt_q <= bit_vld ? 10'd0 : idle_cnt_q + 10'd1;
            if (bit_vld) begin
              sh_q <= sh_nxt;
              if (sym_done) begin
                bit_cnt_q <= '0;
                sym_idx_q <= sym_idx_q + 2'd1;
                if (sh_nxt != exp_sym) begin
                  mism_q <= 1'b1;
                end
                if (sym_ok && (sym_idx_q == 2'd3)) begin
                  sop_q     <= 1'b1;
                  state_q   <= StData;
                  sym_cnt_q <= '0;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end

          StData: begin
            idle_cnt_q <= bit_vld ? 10'd0 : idle_cnt_q + 10'd1;
            if (bit_vld) begin
              sh_q <= sh_nxt;
              if (sym_done) begin
                bit_cnt_q <= '0;
                sym_q     <= sh_nxt;
                vld_q     <= 1'b1;
                sym_cnt_q <= sym_cnt_inc;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end

          default: state_q <= StIdle;
        endcase

        // Packet end or abort: pulse, flush the decoder and resume hunting.
        if (sop_abort || data_abort || data_eop) begin
          err_q      <= sop_abort || data_abort;
          eop_q      <= data_eop;
          clr_q      <= 1'b1;
          state_q    <= StHunt;
          sh_q       <= '0;
          bit_cnt_q  <= '0;
          idle_cnt_q <= '0;
          alt_cnt_q  <= '0;
          prev_vld_q <= 1'b0;
        end
      end
    end
  end

  assign bus.phy_bmc_decoder_clr = clr_q;
  assign bus.phy_bmc_decoder_dis = dis_q;
  assign bus.rx_sym              = sym_q;
  assign bus.rx_sym_vld          = vld_q;
  assign bus.rx_sop              = sop_q;
  assign bus.rx_eop              = eop_q;
  assign bus.rx_err              = err_q;
  assign bus.rx_busy             = busy_q;

endmodule
